// File: rtl/alu_arbiter_pkg.sv
// Shared types and encodings for the two-requester ALU arbiter.
// Holds the FSM states, the opcode unit-select field encodings and the per-unit operation codes.
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_SHIFT = 2'b10;
   localparam logic [1:0] UNIT_RSVD  = 2'b11;

   localparam int NUM_REQ = 2;

   // Operation field (opcode[2:0]) encodings, interpreted per unit
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_INC  = 3'd3;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;

   localparam logic [2:0] OP_SLL  = 3'd0;
   localparam logic [2:0] OP_SRL  = 3'd1;
   localparam logic [2:0] OP_SRA  = 3'd2;
   localparam logic [2:0] OP_ROL  = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational parameterized ALU: arithmetic, logic and shift units selected by opcode[4:3].
// Only the arithmetic unit produces a carry or a product; the reserved unit flags an error.
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SHIFT_BITS = $clog2(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   input  logic [4:0]              opcode,
   input  logic [SHIFT_BITS-1:0]   shamt,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    carry,
   output logic [2*DATA_WIDTH-1:0] mult,
   output logic                    err
);

   localparam int W = DATA_WIDTH;

   logic [W:0]              sum_add;
   logic [W:0]              sum_sub;
   logic [W:0]              sum_inc;
   logic [2*W-1:0]          prod;
   logic signed [W-1:0]     a_s;
   logic signed [W-1:0]     sra;
   logic [2*W-1:0]          rot_l;
   logic [2*W-1:0]          rot_r;

   assign sum_add = {1'b0, a} + {1'b0, b};
   assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
   assign sum_inc = {1'b0, a} + {{W{1'b0}}, 1'b1};
   assign prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   assign a_s     = a;
   assign sra     = a_s >>> shamt;
   assign rot_l   = {a, a} << shamt;
   assign rot_r   = {a, a} >> shamt;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      mult   = '0;
      err    = 1'b0;
      case (opcode[4:3])
         UNIT_ARITH: begin
            mult = prod;
            case (opcode[2:0])
               OP_ADD:  {carry, result} = sum_add;
               OP_SUB:  {carry, result} = sum_sub;
               OP_MUL:  begin
                  result = prod[W-1:0];
                  carry  = |prod[2*W-1:W];
               end
               OP_INC:  {carry, result} = sum_inc;
               default: ;
            endcase
         end
         UNIT_LOGIC: begin
            case (opcode[2:0])
               OP_AND:  result = a & b;
               OP_OR:   result = a | b;
               OP_XOR:  result = a ^ b;
               OP_NOT:  result = ~a;
               OP_NAND: result = ~(a & b);
               OP_NOR:  result = ~(a | b);
               OP_XNOR: result = ~(a ^ b);
               default: result = a;
            endcase
         end
         UNIT_SHIFT: begin
            case (opcode[2:0])
               OP_SLL:  result = a << shamt;
               OP_SRL:  result = a >> shamt;
               OP_SRA:  result = sra;
               OP_ROL:  result = rot_l[2*W-1:W];
               OP_ROR:  result = rot_r[W-1:0];
               default: result = a;
            endcase
         end
         UNIT_RSVD: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that serializes two requesters onto one shared ALU.
// Each command goes IDLE (grant+latch) -> EXEC (compute into rsp regs) -> RESP (hold until taken).
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SHIFT_BITS = $clog2(DATA_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   input  logic [NUM_REQ*5-1:0]          req_opcode,
   input  logic [NUM_REQ*SHIFT_BITS-1:0] req_shamt,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic                          rsp_carry,
   output logic [2*DATA_WIDTH-1:0]       rsp_mult,
   output logic                          rsp_err,
   output logic                          busy
);

   localparam int W = DATA_WIDTH;

   state_t                  state;
   logic                    last_grant;
   logic                    grant_id;
   logic                    accept;
   logic                    cmd_id_p0;
   logic [W-1:0]            a_p0;
   logic [W-1:0]            b_p0;
   logic [4:0]              op_p0;
   logic [SHIFT_BITS-1:0]   sh_p0;
   logic [W-1:0]            alu_result;
   logic                    alu_carry;
   logic [2*W-1:0]          alu_mult;
   logic                    alu_err;

   // On a tie the requester not served last wins; a lone requester always wins
   always_comb begin
      grant_id  = req_valid[1];
      req_ready = '0;
      if (req_valid == 2'b11) grant_id = ~last_grant;
      if (rst_n && state == IDLE && |req_valid) req_ready = grant_id ? 2'b10 : 2'b01;
   end

   assign accept = |req_ready;
   assign busy   = (state != IDLE);

   // Command latch (stage 0): data only, so no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0  <= grant_id ? req_a[2*W-1:W] : req_a[W-1:0];
         b_p0  <= grant_id ? req_b[2*W-1:W] : req_b[W-1:0];
         op_p0 <= grant_id ? req_opcode[9:5] : req_opcode[4:0];
         sh_p0 <= grant_id ? req_shamt[2*SHIFT_BITS-1:SHIFT_BITS] : req_shamt[SHIFT_BITS-1:0];
      end
   end

   alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_BITS (SHIFT_BITS)
   ) u_alu (
      .a      (a_p0),
      .b      (b_p0),
      .opcode (op_p0),
      .shamt  (sh_p0),
      .result (alu_result),
      .carry  (alu_carry),
      .mult   (alu_mult),
      .err    (alu_err)
   );

   // Response registers (stage 1) and control FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cmd_id_p0  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_mult   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= grant_id;
                  cmd_id_p0  <= grant_id;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_carry  <= alu_carry;
               rsp_mult   <= alu_mult;
               rsp_err    <= alu_err;
               rsp_id     <= cmd_id_p0;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked against
// an arithmetic reference of the ALU and a round-robin grant model.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [9:0]  req_opcode;
   logic [5:0]  req_shamt;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [7:0]  rsp_result;
   logic        rsp_carry;
   logic [15:0] rsp_mult;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int model_last = 1;

   int ca [2];
   int cb [2];
   int cop [2];
   int csh [2];

   alu_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_opcode (req_opcode),
      .req_shamt  (req_shamt),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_mult   (rsp_mult),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ALU in plain integer arithmetic
   task automatic ref_alu(input int op, input int a, input int b, input int sh,
                          output int res, output int cy, output int mul, output int er);
      int unit, f;
      unit = op / 8;
      f    = op % 8;
      res = 0; cy = 0; mul = 0; er = 0;
      case (unit)
         0: begin
            mul = a * b;
            case (f)
               0: begin res = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
               1: begin res = (a - b + 256) % 256; cy = (a >= b) ? 1 : 0; end
               2: begin res = (a * b) % 256; cy = (a * b > 255) ? 1 : 0; end
               3: begin res = (a + 1) % 256; cy = (a == 255) ? 1 : 0; end
               default: ;
            endcase
         end
         1: begin
            case (f)
               0: res = a & b;
               1: res = a | b;
               2: res = a ^ b;
               3: res = 255 - a;
               4: res = 255 - (a & b);
               5: res = 255 - (a | b);
               6: res = 255 - (a ^ b);
               default: res = a;
            endcase
         end
         2: begin
            case (f)
               0: res = (a << sh) % 256;
               1: res = a >> sh;
               2: res = (a >= 128) ? ((a >> sh) | ((255 << (8 - sh)) & 255)) : (a >> sh);
               3: res = ((a << sh) | (a >> (8 - sh))) & 255;
               4: res = ((a >> sh) | (a << (8 - sh))) & 255;
               default: res = a;
            endcase
         end
         default: er = 1;
      endcase
   endtask

   task automatic set_cmd(input int i, input int a, input int b, input int op, input int sh);
      ca[i] = a; cb[i] = b; cop[i] = op; csh[i] = sh;
      req_a[i*8 +: 8]      = a[7:0];
      req_b[i*8 +: 8]      = b[7:0];
      req_opcode[i*5 +: 5] = op[4:0];
      req_shamt[i*3 +: 3]  = sh[2:0];
   endtask

   task automatic rand_cmds();
      for (int i = 0; i < 2; i++)
         set_cmd(i, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 31), $urandom_range(0, 7));
   endtask

   function automatic int exp_grant(input logic [1:0] v);
      if (v == 2'b11) return 1 - model_last;
      return (v == 2'b10) ? 1 : 0;
   endfunction

   // Raises v, waits for the grant, then follows the command through EXEC and RESP
   task automatic grant_phase(input logic [1:0] v, input string tag, output int g);
      int n;
      req_valid = v;
      #1;
      g = exp_grant(v);
      n = 0;
      while (req_ready == 2'b00 && n < 8) begin
         @(posedge clk); #1; n++;
      end
      check({tag, " ready"}, req_ready, (g == 1) ? 2 : 1);
      model_last = g;
      @(posedge clk); #1;
      check({tag, " exec busy"}, busy, 1);
      check({tag, " exec rsp_valid"}, rsp_valid, 0);
      check({tag, " exec ready"}, req_ready, 0);
      @(posedge clk); #1;
   endtask

   task automatic check_rsp(input int g, input string tag);
      int res, cy, mul, er;
      ref_alu(cop[g], ca[g], cb[g], csh[g], res, cy, mul, er);
      check({tag, " rsp_valid"}, rsp_valid, 1);
      check({tag, " rsp_id"}, rsp_id, g);
      check({tag, " result"}, rsp_result, res);
      check({tag, " carry"}, rsp_carry, cy);
      check({tag, " mult"}, rsp_mult, mul);
      check({tag, " err"}, rsp_err, er);
   endtask

   task automatic txn(input logic [1:0] v, input string tag);
      int g;
      grant_phase(v, tag, g);
      check_rsp(g, tag);
      @(posedge clk); #1;
      check({tag, " idle busy"}, busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rsp_valid"}, rsp_valid, 0);
      check({tag, " rsp_id"}, rsp_id, 0);
      check({tag, " result"}, rsp_result, 0);
      check({tag, " carry"}, rsp_carry, 0);
      check({tag, " mult"}, rsp_mult, 0);
      check({tag, " err"}, rsp_err, 0);
      check({tag, " req_ready"}, req_ready, 0);
      check({tag, " busy"}, busy, 0);
   endtask

   task automatic do_reset();
      req_valid = 2'b00;
      rst_n = 1'b0;
      model_last = 1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int g;
      rst_n      = 1'b0;
      rsp_ready  = 1'b1;
      req_valid  = 2'b11;
      req_a      = '0;
      req_b      = '0;
      req_opcode = '0;
      req_shamt  = '0;
      rand_cmds();
      #23;
      check_all_zero("reset");
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Add with carry-out from requester 0
      set_cmd(0, 8'hFF, 8'h01, 5'b00000, 0);
      txn(2'b01, "add_ff_01");

      // Tie-breaking order after a fresh reset
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rand_cmds();
         txn(2'b11, $sformatf("rr%0d", i));
      end

      // Reserved unit from requester 1
      set_cmd(1, 8'hA5, 8'h5A, 5'b11000, 3);
      txn(2'b10, "rsvd");

      // Logic unit (XOR) with operands that would carry under addition
      set_cmd(0, 8'hF0, 8'h3C, 5'b01010, 0);
      txn(2'b01, "logic_xor");

      // Back-pressure: response held while both requesters wait
      rand_cmds();
      rsp_ready = 1'b0;
      grant_phase(2'b11, "hold", g);
      check_rsp(g, "hold0");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_rsp(g, $sformatf("hold%0d", i + 1));
         check("hold ready", req_ready, 0);
         check("hold busy", busy, 1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("hold release busy", busy, 0);
      check("hold release ready", req_ready, (exp_grant(2'b11) == 1) ? 2 : 1);
      txn(2'b11, "after_hold");

      // Reset asserted while a command is in EXEC
      rand_cmds();
      req_valid = 2'b11;
      #1;
      for (int n = 0; n < 8 && req_ready == 2'b00; n++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("mid exec busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      req_valid = 2'b00;
      model_last = 1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post reset rsp_valid", rsp_valid, 0);
      end
      rand_cmds();
      txn(2'b11, "post_reset_tie");

      // Randomized traffic, including requesters that change or drop valid between commands
      for (int i = 0; i < 24; i++) begin
         rand_cmds();
         txn(2'($urandom_range(1, 3)), $sformatf("rand%0d", i));
      end

      req_valid = 2'b00;
      @(posedge clk); #1;
      check("final idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
